// File: rtl/click_pkg.sv
// Shared types and constants for the clocked-to-click two-phase transmitter.
package click_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic CLICK_PHASE_RESET = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the count.
module sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [DWIDTH-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DWIDTH-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Guarding here keeps overflow/underflow impossible regardless of the caller.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/click_sync_tx.sv
// Two-phase bundled-data transmitter feeding a click element from a clocked,
// valid/ready source; the returning acknowledge is synchronised before use.
module click_sync_tx
  import click_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DWIDTH-1:0]      i_data,
  output logic                   o_req,
  output logic [DWIDTH-1:0]      o_data,
  input  logic                   i_ack,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_count
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_req;
  logic [DWIDTH-1:0]      r_data;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_toggle;
  logic [DWIDTH-1:0]      w_head;

  assign w_push  = i_valid && !w_full;
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ack_sync <= '0;
    else       r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack};
  end

  // Emptiness is judged on the registered count, so a same-cycle push is never popped.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_toggle    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_toggle    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_ack_s == r_req) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_req   <= CLICK_PHASE_RESET;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_toggle) r_req  <= ~r_req;
      if (w_pop)    r_data <= w_head;
    end
  end

  assign o_req   = r_req;
  assign o_data  = r_data;
  assign o_ready = !w_full;
  assign o_busy  = (r_state != IDLE) || !w_empty;

endmodule

// File: doc/click_sync_tx.md
# click_sync_tx

Clocked two-phase (transition-signalling) bundled-data transmitter that sits directly upstream of a click element and drives its request input. Words accepted on a synchronous valid/ready port are buffered in a small FIFO, then launched one at a time by toggling `o_req` with `o_data` held stable. The click stage's acknowledge returns asynchronously and is synchronised before a word is retired. The block is the entry point from the clocked domain into the click pipeline.

## Interface
- `DWIDTH`, 8: data word width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: flip-flops in the `i_ack` synchroniser; ≥2.

- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  upstream word valid.
- `o_ready`  out  1  FIFO can accept; `= !full`.
- `i_data`  in  DWIDTH  upstream word.
- `o_req`  out  1  two-phase request to click element; every toggle launches one word.
- `o_data`  out  DWIDTH  bundled data; stable from one cycle before the `o_req` toggle until the ack matches.
- `i_ack`  in  1  two-phase acknowledge from click element; asynchronous to `i_clk`.
- `o_busy`  out  1  `state != IDLE || count != 0`.
- `o_count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push on `i_valid && o_ready`. Pop only in the FSM transitions that load `o_data`. Pop never bypasses a same-cycle push: an empty FIFO pops nothing that cycle.
- `ack_s` is `i_ack` after `SYNC_STAGES` flops. A handshake completes when `ack_s == o_req`.
- FSM states:
  - IDLE: if `count != 0`, pop the head into `o_data` and go to SETUP.
  - SETUP: toggle `o_req` and go to WAIT. This gives one full cycle of data setup before the request edge.
  - WAIT: hold `o_data` and `o_req`. When `ack_s == o_req`:
    - if `count != 0`, pop into `o_data` and go to SETUP;
    - otherwise go to IDLE.
- Simultaneous push and pop in WAIT→SETUP with the FIFO full: the pop frees a slot, but `o_ready` is registered from the pre-pop count, so no push occurs that cycle.
- Pointers wrap modulo DEPTH. `count` saturates logically: the full/empty rules make overflow and underflow impossible.
- An `i_ack` toggle while not in WAIT is a protocol error. It is ignored; its effect appears only as `ack_s != o_req` in the next WAIT, where the block keeps waiting.

## Timing
- Reset values: `o_req=0`, `o_data=0`, `o_count=0`, `o_ready=1`, `o_busy=0`, state IDLE, synchroniser flops 0, FIFO pointers 0.
- Reset mid-handshake returns the phase to 0 and discards buffered words. The downstream click element shares `i_rst` and resets its phase to 0 at the same time.
- Latency, word pushed at edge k into an empty, idle block:
  - `o_count`=1 after edge k;
  - `o_data` valid after edge k+1;
  - `o_req` toggles at edge k+2.
- Ack return: an `i_ack` toggle is seen as `ack_s` after `SYNC_STAGES` edges. The FSM leaves WAIT on the next edge.
- Back-to-back throughput: one word per (2 + `SYNC_STAGES` + downstream ack delay) cycles, i.e. at least 4 cycles per word with `SYNC_STAGES`=2.
- `o_ready` and `o_count` update on the edge after a push or pop.

## Structure
- Package `click_pkg`:
  - `state_t` enum: IDLE=2'd0, SETUP=2'd1, WAIT=2'd2;
  - `CLICK_PHASE_RESET=1'b0`.
- Sub-module `sync_fifo` (DWIDTH, DEPTH): push/pop/full/empty/count, asynchronous active-high reset.
- The ack synchroniser and FSM are inline in `click_sync_tx`.

## Test plan
- Reset then single word: push 0xA5 at edge 1.
  - `o_data`=0xA5 after edge 2; `o_req` 0→1 at edge 3.
  - Toggle `i_ack` to 1: FSM returns to IDLE 3 edges later; `o_busy`=0.
- Fill: push 0x01..0x05 with no ack.
  - 0x01 is launched and frees one slot. `o_ready` drops after 0x05 is accepted (4 in FIFO, 1 in flight).
  - No further push is accepted while `o_ready`=0.
- Stream of 8 words with ack looped back 1 cycle after `o_req`:
  - `o_req` toggles 8 times, ending at 0;
  - `o_data` sequence equals input order;
  - each word is stable at every `o_req` edge.
- Empty-with-push corner: push while count=0 and FSM in WAIT completes the same cycle. FSM goes to IDLE, then launches the word on the following cycle path (IDLE→SETUP), not in the same edge.
- Spurious `i_ack` toggle in IDLE: no output change. The next launch waits until `ack_s` equals the new `o_req`.
- Assert `i_rst` during WAIT with 3 words buffered: `o_req`=0, `o_count`=0, `o_ready`=1 immediately, without waiting for a clock edge.
